// File: rtl/flex_counter_mc.sv
// Multi-channel flexible counter: NUM_CH independent up/down counters with
// per-channel clear, load, programmable terminal value, and wrap indication.
module flex_counter_mc #(
    parameter int unsigned NUM_CNT_BITS = 4,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned WRAP_TO_ZERO = 0
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_CH-1:0]              clear,
    input  logic [NUM_CH-1:0]              count_enable,
    input  logic [NUM_CH-1:0]              count_down,
    input  logic [NUM_CH-1:0]              load,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
    output logic [NUM_CH-1:0]              rollover_flag,
    output logic [NUM_CH-1:0]              rollover_pulse,
    output logic                           all_rollover
);

    localparam int unsigned N = NUM_CNT_BITS;
    localparam int unsigned CW = NUM_CH * NUM_CNT_BITS;
    localparam logic [N-1:0] BASE = (WRAP_TO_ZERO != 0) ? '0 : N'(1);

    logic [CW-1:0]     count_q, count_d;
    logic [NUM_CH-1:0] flag_q, flag_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;

    // Per-channel next state; priority is clear, then load, then count, else hold.
    always_comb begin
        logic [N-1:0] cur;
        logic [N-1:0] rv;
        logic [N-1:0] term;
        logic [N-1:0] nxt;
        count_d = count_q;
        flag_d  = flag_q;
        pulse_d = '0;
        cur     = '0;
        rv      = '0;
        term    = '0;
        nxt     = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cur  = count_q[i*N +: N];
            rv   = rollover_val[i*N +: N];
            term = count_down[i] ? BASE : rv;
            nxt  = cur;
            if (clear[i]) begin
                count_d[i*N +: N] = '0;
                flag_d[i]         = 1'b0;
            end else if (load[i]) begin
                count_d[i*N +: N] = load_val[i*N +: N];
                flag_d[i]         = (load_val[i*N +: N] == term);
            end else if (count_enable[i]) begin
                if (!count_down[i]) begin
                    // Above-terminal counts fall through to a plain increment.
                    if (cur == rv) begin
                        nxt        = BASE;
                        pulse_d[i] = 1'b1;
                    end else begin
                        nxt = cur + N'(1);
                    end
                end else begin
                    if (cur <= BASE) begin
                        nxt        = rv;
                        pulse_d[i] = 1'b1;
                    end else begin
                        nxt = cur - N'(1);
                    end
                end
                count_d[i*N +: N] = nxt;
                flag_d[i]         = (nxt == term);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= '0;
            pulse_q <= '0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            pulse_q <= pulse_d;
        end
    end

    assign count_out      = count_q;
    assign rollover_flag  = flag_q;
    assign rollover_pulse = pulse_q;
    assign all_rollover   = &flag_q;

endmodule

// File: tb/tb_flex_counter_mc.sv
// Directed self-checking bench for flex_counter_mc: one instance with base 1,
// one with WRAP_TO_ZERO=1.
module tb_flex_counter_mc;

    localparam int unsigned N  = 4;
    localparam int unsigned CH = 2;

    logic clk = 1'b0;
    logic n_rst = 1'b1;

    logic [CH-1:0]   a_clear, a_en, a_down, a_load;
    logic [CH*N-1:0] a_lv, a_rv, a_cnt;
    logic [CH-1:0]   a_flag, a_pulse;
    logic            a_all;

    logic [CH-1:0]   z_clear, z_en, z_down, z_load;
    logic [CH*N-1:0] z_lv, z_rv, z_cnt;
    logic [CH-1:0]   z_flag, z_pulse;
    logic            z_all;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    flex_counter_mc #(.NUM_CNT_BITS(N), .NUM_CH(CH), .WRAP_TO_ZERO(0)) dut (
        .clk(clk), .n_rst(n_rst), .clear(a_clear), .count_enable(a_en),
        .count_down(a_down), .load(a_load), .load_val(a_lv), .rollover_val(a_rv),
        .count_out(a_cnt), .rollover_flag(a_flag), .rollover_pulse(a_pulse),
        .all_rollover(a_all)
    );

    flex_counter_mc #(.NUM_CNT_BITS(N), .NUM_CH(CH), .WRAP_TO_ZERO(1)) dut_z (
        .clk(clk), .n_rst(n_rst), .clear(z_clear), .count_enable(z_en),
        .count_down(z_down), .load(z_load), .load_val(z_lv), .rollover_val(z_rv),
        .count_out(z_cnt), .rollover_flag(z_flag), .rollover_pulse(z_pulse),
        .all_rollover(z_all)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 n_rst = 1'b0;
        #1;
        compared++;
        if (a_cnt !== 8'h00 || a_flag !== 2'b00 || a_pulse !== 2'b00 || a_all !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_a: cnt=%h flag=%b pulse=%b all=%b expected 00/00/00/0", a_cnt, a_flag, a_pulse, a_all);
        end
        compared++;
        if (z_cnt !== 8'h00 || z_flag !== 2'b00 || z_pulse !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_z: cnt=%h flag=%b pulse=%b expected 00/00/00", z_cnt, z_flag, z_pulse);
        end
        a_en = 2'b11;
        tick();
        tick();
        compared++;
        if (a_cnt !== 8'h00 || a_flag !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_hold: cnt=%h flag=%b expected 00/00", a_cnt, a_flag);
        end
        a_en = 2'b00;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_up();
        int exp_c[7] = '{1, 2, 3, 4, 5, 1, 2};
        int exp_f[7] = '{0, 0, 0, 0, 1, 0, 0};
        int exp_p[7] = '{0, 0, 0, 0, 0, 1, 0};
        a_rv[3:0] = 4'd5;
        a_en = 2'b01;
        for (int k = 0; k < 7; k++) begin
            tick();
            compared++;
            if (a_cnt[3:0] !== 4'(exp_c[k])) begin
                mismatched++;
                $display("FAIL up_cnt[%0d]: got %0d expected %0d", k, a_cnt[3:0], exp_c[k]);
            end
            compared++;
            if (a_flag[0] !== 1'(exp_f[k]) || a_pulse[0] !== 1'(exp_p[k])) begin
                mismatched++;
                $display("FAIL up_flag_pulse[%0d]: got %b/%b expected %0d/%0d", k, a_flag[0], a_pulse[0], exp_f[k], exp_p[k]);
            end
            compared++;
            if (a_cnt[7:4] !== 4'd0) begin
                mismatched++;
                $display("FAIL up_ch1_frozen[%0d]: got %0d expected 0", k, a_cnt[7:4]);
            end
        end
        a_en = 2'b00;
    endtask

    task automatic test_down();
        int exp_c[4] = '{2, 1, 3, 2};
        int exp_f[4] = '{0, 1, 0, 0};
        int exp_p[4] = '{0, 0, 1, 0};
        a_down = 2'b01;
        a_rv[3:0] = 4'd3;
        a_lv[3:0] = 4'd3;
        a_load = 2'b01;
        tick();
        compared++;
        if (a_cnt[3:0] !== 4'd3 || a_flag[0] !== 1'b0 || a_pulse[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL down_load: got %0d/%b/%b expected 3/0/0", a_cnt[3:0], a_flag[0], a_pulse[0]);
        end
        a_load = 2'b00;
        a_en = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (a_cnt[3:0] !== 4'(exp_c[k]) || a_flag[0] !== 1'(exp_f[k]) || a_pulse[0] !== 1'(exp_p[k])) begin
                mismatched++;
                $display("FAIL down[%0d]: got %0d/%b/%b expected %0d/%0d/%0d", k, a_cnt[3:0], a_flag[0], a_pulse[0], exp_c[k], exp_f[k], exp_p[k]);
            end
        end
        a_en = 2'b00;
        a_down = 2'b00;
    endtask

    task automatic test_clear_load();
        a_clear = 2'b01;
        a_load = 2'b01;
        a_en = 2'b01;
        a_lv[3:0] = 4'd5;
        tick();
        compared++;
        if (a_cnt[3:0] !== 4'd0 || a_flag[0] !== 1'b0 || a_pulse[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL clear_priority: got %0d/%b/%b expected 0/0/0", a_cnt[3:0], a_flag[0], a_pulse[0]);
        end
        a_clear = 2'b00;
        a_en = 2'b00;
        a_rv[3:0] = 4'd5;
        tick();
        compared++;
        if (a_cnt[3:0] !== 4'd5 || a_flag[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL load_term: got %0d/%b expected 5/1", a_cnt[3:0], a_flag[0]);
        end
        a_load = 2'b00;
        tick();
        compared++;
        if (a_cnt[3:0] !== 4'd5 || a_flag[0] !== 1'b1 || a_pulse[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL hold: got %0d/%b/%b expected 5/1/0", a_cnt[3:0], a_flag[0], a_pulse[0]);
        end
    endtask

    task automatic test_all_rollover();
        compared++;
        if (a_all !== 1'b0) begin
            mismatched++;
            $display("FAIL all_one_flag: got %b expected 0", a_all);
        end
        a_rv[7:4] = 4'd9;
        a_lv[7:4] = 4'd9;
        a_load = 2'b10;
        tick();
        compared++;
        if (a_cnt[7:4] !== 4'd9 || a_flag !== 2'b11 || a_all !== 1'b1) begin
            mismatched++;
            $display("FAIL all_both: cnt1=%0d flag=%b all=%b expected 9/11/1", a_cnt[7:4], a_flag, a_all);
        end
        a_load = 2'b00;
        a_en = 2'b01;
        tick();
        compared++;
        if (a_cnt !== 8'h91 || a_flag !== 2'b10 || a_pulse !== 2'b01 || a_all !== 1'b0) begin
            mismatched++;
            $display("FAIL all_wrap: cnt=%h flag=%b pulse=%b all=%b expected 91/10/01/0", a_cnt, a_flag, a_pulse, a_all);
        end
        a_en = 2'b00;
    endtask

    task automatic test_wrap_zero();
        int exp_c[3] = '{14, 15, 0};
        int exp_f[3] = '{0, 1, 0};
        int exp_p[3] = '{0, 0, 1};
        z_rv[3:0] = 4'd15;
        z_lv[3:0] = 4'd13;
        z_load = 2'b01;
        tick();
        z_load = 2'b00;
        z_en = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (z_cnt[3:0] !== 4'(exp_c[k]) || z_flag[0] !== 1'(exp_f[k]) || z_pulse[0] !== 1'(exp_p[k])) begin
                mismatched++;
                $display("FAIL wz_up[%0d]: got %0d/%b/%b expected %0d/%0d/%0d", k, z_cnt[3:0], z_flag[0], z_pulse[0], exp_c[k], exp_f[k], exp_p[k]);
            end
        end
        z_en = 2'b00;
        z_lv[3:0] = 4'd7;
        z_load = 2'b01;
        tick();
        z_load = 2'b00;
        z_rv[3:0] = 4'd2;
        z_en = 2'b01;
        for (int k = 0; k < 11; k++) begin
            tick();
            compared++;
            if (z_cnt[3:0] !== 4'((8 + k) % 16) || z_flag[0] !== 1'(k == 10) || z_pulse[0] !== 1'b0) begin
                mismatched++;
                $display("FAIL wz_above[%0d]: got %0d/%b/%b expected %0d/%0d/0", k, z_cnt[3:0], z_flag[0], z_pulse[0], (8 + k) % 16, (k == 10));
            end
        end
        tick();
        compared++;
        if (z_cnt[3:0] !== 4'd0 || z_flag[0] !== 1'b0 || z_pulse[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL wz_term_wrap: got %0d/%b/%b expected 0/0/1", z_cnt[3:0], z_flag[0], z_pulse[0]);
        end
        z_en = 2'b00;
    endtask

    task automatic test_back_to_back();
        z_rv[7:4] = 4'd0;
        z_lv[7:4] = 4'd0;
        z_load = 2'b10;
        tick();
        compared++;
        if (z_cnt[7:4] !== 4'd0 || z_flag[1] !== 1'b1 || z_pulse[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_load: got %0d/%b/%b expected 0/1/0", z_cnt[7:4], z_flag[1], z_pulse[1]);
        end
        z_load = 2'b00;
        z_en = 2'b10;
        for (int k = 0; k < 2; k++) begin
            tick();
            compared++;
            if (z_cnt[7:4] !== 4'd0 || z_flag[1] !== 1'b1 || z_pulse[1] !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_pulse[%0d]: got %0d/%b/%b expected 0/1/1", k, z_cnt[7:4], z_flag[1], z_pulse[1]);
            end
        end
        z_en = 2'b00;
        tick();
        compared++;
        if (z_pulse[1] !== 1'b0 || z_flag[1] !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_idle: got pulse %b flag %b expected 0/1", z_pulse[1], z_flag[1]);
        end
    endtask

    task automatic test_async_reset();
        a_en = 2'b01;
        tick();
        tick();
        tick();
        compared++;
        if (a_cnt[3:0] !== 4'd4) begin
            mismatched++;
            $display("FAIL areset_pre: got %0d expected 4", a_cnt[3:0]);
        end
        #2 n_rst = 1'b0;
        #1;
        compared++;
        if (a_cnt !== 8'h00 || a_flag !== 2'b00 || a_pulse !== 2'b00 || a_all !== 1'b0) begin
            mismatched++;
            $display("FAIL areset_now: cnt=%h flag=%b pulse=%b all=%b expected 00/00/00/0", a_cnt, a_flag, a_pulse, a_all);
        end
        #1 n_rst = 1'b1;
        tick();
        compared++;
        if (a_cnt !== 8'h01 || a_flag !== 2'b00 || a_pulse !== 2'b00) begin
            mismatched++;
            $display("FAIL areset_resume: cnt=%h flag=%b pulse=%b expected 01/00/00", a_cnt, a_flag, a_pulse);
        end
        a_en = 2'b00;
    endtask

    initial begin
        a_clear = '0; a_en = '0; a_down = '0; a_load = '0; a_lv = '0; a_rv = '0;
        z_clear = '0; z_en = '0; z_down = '0; z_load = '0; z_lv = '0; z_rv = '0;
        test_reset();
        test_up();
        test_down();
        test_clear_load();
        test_all_rollover();
        test_wrap_zero();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/flex_counter_mc.md
FLEX_COUNTER_MC -- requirements
Module: flex_counter_mc

Interface
REQ-001 Parameter NUM_CNT_BITS, default 4, SHALL set the width of each channel's counter.
REQ-002 Parameter NUM_CH, default 2, SHALL set the number of independent counter channels.
REQ-003 Parameter WRAP_TO_ZERO, default 0, SHALL set the wrap base B: B=0 when WRAP_TO_ZERO=1, else B=1.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 clear  input  NUM_CH  per-channel synchronous clear.
REQ-007 count_enable  input  NUM_CH  per-channel count strobe.
REQ-008 count_down  input  NUM_CH  per-channel direction: 0 = up, 1 = down.
REQ-009 load  input  NUM_CH  per-channel synchronous load strobe.
REQ-010 load_val  input  NUM_CH*NUM_CNT_BITS  packed load values; channel i occupies bits [i*NUM_CNT_BITS +: NUM_CNT_BITS].
REQ-011 rollover_val  input  NUM_CH*NUM_CNT_BITS  packed per-channel terminal values, same packing as load_val.
REQ-012 count_out  output  NUM_CH*NUM_CNT_BITS  packed registered counts, same packing.
REQ-013 rollover_flag  output  NUM_CH  registered; high while the channel sits on its terminal value.
REQ-014 rollover_pulse  output  NUM_CH  registered; one-cycle pulse on each wrap.
REQ-015 all_rollover  output  1  combinational AND of all rollover_flag bits.

Function
REQ-016 Channels SHALL be fully independent; channel i SHALL use only bit i (or slice i) of each vector.
REQ-017 Terminal value T SHALL be rollover_val[i] when count_down[i]=0 and B when count_down[i]=1.
REQ-018 Per-channel priority SHALL be clear > load > count_enable > hold.
REQ-019 Clear: count <= 0, rollover_flag <= 0, rollover_pulse <= 0 on the next edge.
REQ-020 Load: count <= load_val[i], rollover_flag <= (load_val[i]==T), rollover_pulse <= 0.
REQ-021 Up count: if count==rollover_val[i], next = B and rollover_pulse <= 1; otherwise next = count+1 modulo 2^NUM_CNT_BITS and rollover_pulse <= 0.
REQ-022 Down count: if count<=B, next = rollover_val[i] and rollover_pulse <= 1; otherwise next = count-1 and rollover_pulse <= 0.
REQ-023 On any counting cycle, rollover_flag SHALL be set to (next==T).
REQ-024 Hold (no clear/load/enable): count and rollover_flag SHALL retain their values and rollover_pulse SHALL be 0.
REQ-025 Up count above rollover_val[i] (e.g. after rollover_val is lowered) SHALL continue incrementing, wrap 2^N-1 -> 0 naturally, and raise no pulse for that natural wrap.
REQ-026 A count_down change SHALL take effect on the same cycle it is sampled; no state is kept per direction.
REQ-027 Latency: count_out, rollover_flag and rollover_pulse SHALL update exactly one clock after the qualifying inputs are sampled.
REQ-028 rollover_pulse SHALL never stay high for two cycles unless a wrap occurs on consecutive enabled cycles (e.g. rollover_val==B).

Reset
REQ-029 While n_rst=0, every count_out slice SHALL be 0 and rollover_flag and rollover_pulse SHALL be all 0, regardless of clk.
REQ-030 Reset asserted mid-count SHALL abort the count immediately; counting SHALL resume from 0 on the first enabled edge after deassertion.

Verification
REQ-031 Up, N=4, B=1, rollover_val=5, enable held -> count 1,2,3,4,5,1,2; flag high only when count=5; pulse on the cycle count returns to 1.
REQ-032 Down, rollover_val=3, load 3 then enable -> count 2,1,3,2; flag high at 1; pulse when count returns to 3.
REQ-033 Clear and load asserted together with enable -> count 0, flag 0. Then load alone with load_val=5 and rollover_val=5 -> count 5, flag 1.
REQ-034 WRAP_TO_ZERO=1, rollover_val=15, up -> count 14,15,0 with pulse on the 0 cycle. rollover_val changed to 2 while count=7 -> count 8..15,0,1,2 with no pulse at the natural wrap and flag at 2.
REQ-035 NUM_CH=2, enable ch0 only -> ch1 count frozen. all_rollover asserts only when both flags are high.
REQ-036 n_rst pulsed low mid-count at count=4 -> all outputs 0 asynchronously, before the next clk edge.
